// File: rtl/multi_register_bank.sv
// Datapath register file: NREGS registers sharing one FunSel, gated per register by RegSel.
// Two combinational read ports plus a registered boundary-hit flag for increment/decrement.
module multi_register_bank #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter bit SAT   = 1'b0,
  localparam int SW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [NREGS-1:0] RegSel,
  input  logic [3:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  input  logic [SW-1:0]    OutASel,
  input  logic [SW-1:0]    OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             Wrap
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] hit_s;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] out_a_s;
  logic [WIDTH-1:0] out_b_s;

  function automatic logic boundary_hit(input logic [WIDTH-1:0] q, input logic [3:0] fs);
    logic hit;
    case (fs)
      4'b0000: hit = (q == ZERO);
      4'b0001: hit = (q == ONES);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Saturating mode keeps the boundary value instead of wrapping around.
  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] q,
                                                input logic [3:0]       fs,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] res;
    case (fs)
      4'b0000: res = (SAT && (q == ZERO)) ? q : q - ONE;
      4'b0001: res = (SAT && (q == ONES)) ? q : q + ONE;
      4'b0010: res = d;
      4'b0011: res = ZERO;
      4'b0100: res = {{(WIDTH-H){1'b0}}, d[H-1:0]};
      4'b0101: res = {q[WIDTH-1:H], d[H-1:0]};
      4'b0110: res = {d[H-1:0], q[H-1:0]};
      4'b0111: res = {{(WIDTH-H){d[H-1]}}, d[H-1:0]};
      4'b1000: res = {q[WIDTH-2:0], 1'b0};
      4'b1001: res = {1'b0, q[WIDTH-1:1]};
      4'b1010: res = {q[WIDTH-1], q[WIDTH-1:1]};
      4'b1011: res = {q[WIDTH-2:0], q[WIDTH-1]};
      4'b1100: res = {q[0], q[WIDTH-1:1]};
      4'b1101: res = {q[H-1:0], q[WIDTH-1:H]};
      4'b1110: res = ~q;
      4'b1111: res = q;
      default: res = q;
    endcase
    return res;
  endfunction

  // Next-state for every register and the combined boundary-hit indication.
  always_comb begin
    wrap_d = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (RegSel[r]) begin
        regs_d[r] = apply_op(regs_q[r], FunSel, I);
        hit_s[r]  = boundary_hit(regs_q[r], FunSel);
      end else begin
        regs_d[r] = regs_q[r];
        hit_s[r]  = 1'b0;
      end
    end
    wrap_d = |hit_s;
  end

  // Register state and wrap flag; reset wins over any operation on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= ZERO;
      end
      wrap_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      wrap_q <= wrap_d;
    end
  end

  // Read muxes; an index with no backing register falls through to zero.
  always_comb begin
    out_a_s = ZERO;
    out_b_s = ZERO;
    for (int r = 0; r < NREGS; r++) begin
      out_a_s = (OutASel == SW'(r)) ? regs_q[r] : out_a_s;
      out_b_s = (OutBSel == SW'(r)) ? regs_q[r] : out_b_s;
    end
  end

  assign OutA = out_a_s;
  assign OutB = out_b_s;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_multi_register_bank.sv
// Directed bench: a wrapping 4x16 bank driven from a vector table, plus a
// saturating 6x16 bank exercised by short hand-written sequences.
module tb_multi_register_bank;

  logic        Clock;
  logic        Reset;
  logic [3:0]  RegSel;
  logic [3:0]  FunSel;
  logic [15:0] I;
  logic [1:0]  OutASel, OutBSel;
  logic [15:0] OutA, OutB;
  logic        Wrap;

  logic [5:0]  s_regsel;
  logic [2:0]  s_asel, s_bsel;
  logic [15:0] s_outa, s_outb;
  logic        s_wrap;

  int pass_cnt  = 0;
  int total_cnt = 0;

  multi_register_bank #(.WIDTH(16), .NREGS(4), .SAT(1'b0)) u_dut (
    .Clock(Clock), .Reset(Reset), .RegSel(RegSel), .FunSel(FunSel), .I(I),
    .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB), .Wrap(Wrap)
  );

  multi_register_bank #(.WIDTH(16), .NREGS(6), .SAT(1'b1)) u_sat (
    .Clock(Clock), .Reset(Reset), .RegSel(s_regsel), .FunSel(FunSel), .I(I),
    .OutASel(s_asel), .OutBSel(s_bsel), .OutA(s_outa), .OutB(s_outb), .Wrap(s_wrap)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  regsel;
    logic [3:0]  funsel;
    logic [15:0] din;
    logic [1:0]  asel;
    logic [1:0]  bsel;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'b0101, 4'b0010, 16'hA5C3, 2'd0, 2'd1, 16'hA5C3, 16'h0000, 1'b0};
    vecs[1]  = '{4'b0000, 4'b0010, 16'h1111, 2'd2, 2'd3, 16'hA5C3, 16'h0000, 1'b0};
    vecs[2]  = '{4'b0010, 4'b0111, 16'h0080, 2'd1, 2'd0, 16'hFF80, 16'hA5C3, 1'b0};
    vecs[3]  = '{4'b0100, 4'b0110, 16'h0012, 2'd2, 2'd0, 16'h12C3, 16'hA5C3, 1'b0};
    vecs[4]  = '{4'b0001, 4'b0010, 16'hFFFF, 2'd0, 2'd1, 16'hFFFF, 16'hFF80, 1'b0};
    vecs[5]  = '{4'b0001, 4'b0001, 16'h0000, 2'd0, 2'd1, 16'h0000, 16'hFF80, 1'b1};
    vecs[6]  = '{4'b0000, 4'b1111, 16'h0000, 2'd0, 2'd1, 16'h0000, 16'hFF80, 1'b0};
    vecs[7]  = '{4'b0001, 4'b0010, 16'h0001, 2'd0, 2'd1, 16'h0001, 16'hFF80, 1'b0};
    vecs[8]  = '{4'b0001, 4'b0000, 16'h0000, 2'd0, 2'd1, 16'h0000, 16'hFF80, 1'b0};
    vecs[9]  = '{4'b0001, 4'b0000, 16'h0000, 2'd0, 2'd1, 16'hFFFF, 16'hFF80, 1'b1};
    vecs[10] = '{4'b1000, 4'b0010, 16'h8001, 2'd3, 2'd2, 16'h8001, 16'h12C3, 1'b0};
    vecs[11] = '{4'b1000, 4'b1010, 16'h0000, 2'd3, 2'd2, 16'hC000, 16'h12C3, 1'b0};
    vecs[12] = '{4'b1000, 4'b1011, 16'h0000, 2'd3, 2'd2, 16'h8001, 16'h12C3, 1'b0};
    vecs[13] = '{4'b1000, 4'b1001, 16'h0000, 2'd3, 2'd2, 16'h4000, 16'h12C3, 1'b0};
    vecs[14] = '{4'b1000, 4'b1101, 16'h0000, 2'd3, 2'd2, 16'h0040, 16'h12C3, 1'b0};
    vecs[15] = '{4'b1000, 4'b1110, 16'h0000, 2'd3, 2'd2, 16'hFFBF, 16'h12C3, 1'b0};
    vecs[16] = '{4'b1010, 4'b1100, 16'h0000, 2'd3, 2'd1, 16'hFFDF, 16'h7FC0, 1'b0};
    vecs[17] = '{4'b0010, 4'b1000, 16'h0000, 2'd1, 2'd3, 16'hFF80, 16'hFFDF, 1'b0};
    vecs[18] = '{4'b0100, 4'b0100, 16'hABCD, 2'd2, 2'd1, 16'h00CD, 16'hFF80, 1'b0};
    vecs[19] = '{4'b0100, 4'b0101, 16'h1234, 2'd2, 2'd1, 16'h0034, 16'hFF80, 1'b0};
    vecs[20] = '{4'b0011, 4'b0001, 16'h0000, 2'd0, 2'd1, 16'h0000, 16'hFF81, 1'b1};
    vecs[21] = '{4'b1111, 4'b1111, 16'h0000, 2'd2, 2'd3, 16'h0034, 16'hFFDF, 1'b0};
    vecs[22] = '{4'b0010, 4'b0011, 16'h0000, 2'd1, 2'd0, 16'h0000, 16'h0000, 1'b0};

    Reset = 1'b1; RegSel = 4'b0000; FunSel = 4'b1111; I = 16'h0000;
    OutASel = 2'd0; OutBSel = 2'd0;
    s_regsel = 6'b000000; s_asel = 3'd0; s_bsel = 3'd0;
    step(); step();

    // Fill every register with 0x1234, then reset must clear them all.
    Reset = 1'b0; RegSel = 4'b1111; FunSel = 4'b0010; I = 16'h1234;
    s_regsel = 6'b111111;
    step();
    chk("preload_r0", OutA, 16'h1234);
    Reset = 1'b1; RegSel = 4'b0000; s_regsel = 6'b000000;
    step();
    OutASel = 2'd0; OutBSel = 2'd1; #1;
    chk("reset_r0", OutA, 16'h0000);
    chk("reset_r1", OutB, 16'h0000);
    OutASel = 2'd2; OutBSel = 2'd3; #1;
    chk("reset_r2", OutA, 16'h0000);
    chk("reset_r3", OutB, 16'h0000);
    chk("reset_wrap", {15'd0, Wrap}, 16'h0000);
    s_asel = 3'd5; #1;
    chk("sat_reset_r5", s_outa, 16'h0000);

    // Saturating bank: load all, out-of-range index, clamp at both ends.
    Reset = 1'b0; s_regsel = 6'b111111; FunSel = 4'b0010; I = 16'hFFFF;
    s_asel = 3'd5; s_bsel = 3'd6;
    step();
    chk("sat_load_r5", s_outa, 16'hFFFF);
    chk("sat_idx6_zero", s_outb, 16'h0000);
    s_bsel = 3'd7; #1;
    chk("sat_idx7_zero", s_outb, 16'h0000);
    s_regsel = 6'b000001; FunSel = 4'b0001; s_asel = 3'd0;
    step();
    chk("sat_inc_hold", s_outa, 16'hFFFF);
    chk("sat_inc_wrap", {15'd0, s_wrap}, 16'h0001);
    s_regsel = 6'b000010; FunSel = 4'b0000; s_asel = 3'd1;
    step();
    chk("sat_dec_val", s_outa, 16'hFFFE);
    chk("sat_dec_nowrap", {15'd0, s_wrap}, 16'h0000);
    FunSel = 4'b0011;
    step();
    FunSel = 4'b0000;
    step();
    chk("sat_dec0_hold", s_outa, 16'h0000);
    chk("sat_dec0_wrap", {15'd0, s_wrap}, 16'h0001);
    s_regsel = 6'b000000; FunSel = 4'b1111;
    step();
    chk("sat_wrap_drop", {15'd0, s_wrap}, 16'h0000);

    // Wrapping bank: table of single-cycle operations starting from all zero.
    for (int k = 0; k < 23; k++) begin
      RegSel = vecs[k].regsel; FunSel = vecs[k].funsel; I = vecs[k].din;
      OutASel = vecs[k].asel; OutBSel = vecs[k].bsel;
      step();
      chk($sformatf("vec%0d_a", k), OutA, vecs[k].exp_a);
      chk($sformatf("vec%0d_b", k), OutB, vecs[k].exp_b);
      chk($sformatf("vec%0d_wrap", k), {15'd0, Wrap}, {15'd0, vecs[k].exp_wrap});
    end

    // No write-through: both ports see the old R1 until the edge.
    RegSel = 4'b0010; FunSel = 4'b0010; I = 16'h5555; OutASel = 2'd1; OutBSel = 2'd1;
    #1;
    chk("wt_before_a", OutA, 16'h0000);
    chk("wt_before_b", OutB, 16'h0000);
    step();
    chk("wt_after_a", OutA, 16'h5555);
    chk("wt_after_b", OutB, 16'h5555);
    RegSel = 4'b1111; FunSel = 4'b1111; OutASel = 2'd3;
    step();
    chk("hold_all_r1", OutB, 16'h5555);
    chk("hold_all_r3", OutA, 16'hFFDF);

    // Reset beats a decrement-of-zero on every register in the same edge.
    RegSel = 4'b1111; FunSel = 4'b0011;
    step();
    FunSel = 4'b0000; Reset = 1'b1;
    step();
    OutASel = 2'd0; OutBSel = 2'd3; #1;
    chk("rstpri_r0", OutA, 16'h0000);
    chk("rstpri_r3", OutB, 16'h0000);
    chk("rstpri_wrap", {15'd0, Wrap}, 16'h0000);
    Reset = 1'b0; RegSel = 4'b0000; FunSel = 4'b1111;
    step();
    chk("rstpri_wrap_next", {15'd0, Wrap}, 16'h0000);

    // First operation right after reset release takes effect immediately.
    RegSel = 4'b0001; FunSel = 4'b0001;
    step();
    chk("post_reset_inc", OutA, 16'h0001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
